// File: rtl/comparador_serie_d_i.sv
// Bit-serial LSB-first magnitude comparator.
// One bit pair per clock; p_x = (A<B) | (A==B & x_init).
module comparador_serie_d_i #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] a_w,
    input  logic [N-1:0] b_w,
    input  logic         x_init,
    output logic         busy,
    output logic         done,
    output logic         p_x
);

    localparam int            CW   = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [N-1:0]  sa_q, sa_d;
    logic [N-1:0]  sb_q, sb_d;
    logic          x_q, x_d;
    logic          px_q, px_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          a_bit, b_bit, x_nxt;

    assign a_bit = sa_q[0];
    assign b_bit = sb_q[0];

    // Later (more significant) bits override the carried state.
    assign x_nxt = (~a_bit & b_bit) | (x_q & ~a_bit) | (x_q & b_bit);

    assign busy = (state_q == RUN);
    assign done = (state_q == DONE);
    assign p_x  = px_q;

    // Next-state and datapath control; everything holds by default.
    always_comb begin
        state_d = state_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        x_d     = x_q;
        px_d    = px_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    sa_d    = a_w;
                    sb_d    = b_w;
                    x_d     = x_init;
                    cnt_d   = '0;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                x_d   = x_nxt;
                sa_d  = sa_q >> 1;
                sb_d  = sb_q >> 1;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    px_d    = x_nxt;
                    cnt_d   = '0;
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers; reset aborts any run and clears the result.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sa_q    <= '0;
            sb_q    <= '0;
            x_q     <= 1'b0;
            px_q    <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            x_q     <= x_d;
            px_q    <= px_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: doc/comparador_serie_d_i.md
# comparador_serie_d_i

Bit-serial, right-to-left (LSB-first) magnitude comparator for the der-izq chain. It loads two N-bit words and processes one bit pair per clock through the comparison cell function, holding the running state x in a register. After N cycles it presents the same result the combinational chain's final cell produces: A < B, or A == B with the initial state carried through. It sits downstream of the word sources and replaces the unrolled cell chain when area matters more than latency.

## Interface
- N, 8, word width in bits (N ≥ 1)
- clk  input  1  rising-edge clock
- rst  input  1  reset, synchronous, active-high
- start  input  1  request a comparison; accepted only in IDLE or DONE
- a_w  input  N  word A, sampled on the accepting edge
- b_w  input  N  word B, sampled on the accepting edge
- x_init  input  1  initial state x (tie result when A == B)
- busy  output  1  high while bits are being processed (RUN)
- done  output  1  one-cycle pulse when p_x is updated
- p_x  output  1  registered comparison result, held until next done

## Operation
- States: IDLE, RUN, DONE.
- IDLE/DONE with start=1:
  - load shift registers sa <= a_w and sb <= b_w;
  - x <= x_init;
  - cnt <= 0;
  - go to RUN.
- RUN, each cycle, with bits a = sa[0] and b = sb[0]:
  - x <= (~a & b) | (x & ~a) | (x & b);
  - shift sa and sb right by 1;
  - cnt <= cnt + 1.
- Transition out of RUN: in the RUN cycle with cnt == N-1, the bit update is computed into p_x directly (p_x <= next x), done <= 1, and the state goes to DONE.
- DONE lasts one cycle, then returns to IDLE unless start=1. Start in DONE begins a new run with no idle gap.
- Result meaning: p_x = 1 iff unsigned A < B, or A == B and x_init = 1. The most significant differing bit decides.
- start while in RUN is ignored; a_w, b_w and x_init are don't-care outside the accepting edge.
- cnt width: $clog2(N) bits, minimum 1. For N=1, RUN lasts exactly one cycle.
- p_x changes only on the done cycle (or reset); it never shows intermediate x.

## Timing
- Accepting edge k (start=1 in IDLE/DONE):
  - busy = 1 after edge k through edge k+N-1, i.e. N cycles;
  - done = 1 and p_x valid after edge k+N, for exactly one cycle;
  - busy = 0 in the done cycle.
- Latency from start to done: N+1 edges inclusive of the accepting edge. Throughput: one comparison per N+1 cycles with back-to-back start.
- Reset values: state IDLE, busy 0, done 0, p_x 0, x 0, cnt 0, sa/sb 0.
- rst has priority over start and over every state. Reset mid-RUN aborts the run: no done, p_x forced to 0.
- Simultaneous done and start (start in the DONE cycle): done still pulses for the finishing result; new words load on that edge.

## Test plan
- N=8, A=0x05, B=0x09, x_init=0 -> after 9 edges done=1, p_x=1; busy high for exactly 8 cycles.
- A=0x09, B=0x05, x_init=1 -> p_x=0. Then A=0x80, B=0x7F -> p_x=0 (MSB dominates LSB differences).
- A=B=0xA5: x_init=1 -> p_x=1; x_init=0 -> p_x=0. p_x holds its value through 5 idle cycles after done.
- Start at edge k, new start pulses at k+3 with different words -> ignored; result matches the first operands; done exactly once at k+8.
- rst asserted at k+4 of a run -> next cycle busy=0, done=0, p_x=0, no later done. A start applied together with rst is ignored.
- Back-to-back runs, with start held high through DONE: (0x10, 0x20) then (0xFF, 0x00) -> done pulses 9 cycles apart with p_x=1 then 0. Also N=1 instance: a=0, b=1 -> done after 2 edges with p_x=1.
